cam_frame_capture: RTL and testbench
====================================

CAM_FRAME_CAPTURE -- requirements
Module: cam_frame_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-buffer address width; H_ACTIVE*V_ACTIVE SHALL fit in ADDR_W bits.
REQ-004 SHALL have ports: pclk in 1 sensor pixel clock; rst_n in 1 reset; single clock pclk, asynchronous active-low reset rst_n.
REQ-005 SHALL have ports: vsync in 1 frame sync (high = blanking); href in 1 line valid; din in 8 sensor byte.
REQ-006 SHALL have ports: cap_en in 1 capture enable; mode in 2 capture mode (0 full RGB565, 1 2x2-decimated RGB565, 2 Y-only YUV422, 3 reserved = no writes); single_shot in 1 stop after one captured frame.
REQ-007 SHALL have ports: addr out ADDR_W write address; dout out 16 pixel word; we out 1 write strobe.
REQ-008 SHALL have ports: frame_done out 1 one-cycle pulse; line_err out 1 sticky malformed-line flag; ovf out 1 sticky address-overflow flag; err_clr in 1 clears both sticky flags.

Function
REQ-009 SHALL sample cap_en, mode and single_shot only on a pclk edge where vsync is high; values SHALL hold for the whole following frame.
REQ-010 SHALL run frame FSM WAIT_VS -> ACTIVE on vsync falling edge when sampled cap_en=1 and not latched-off; ACTIVE -> WAIT_VS on vsync rising edge; any vsync=1 cycle during ACTIVE SHALL abort the current line.
REQ-011 SHALL use byte-phase toggle reset to 0 at href rising edge; phase 0 byte = high byte, phase 1 byte completes pixel {hi, din}.
REQ-012 SHALL keep x counter (pixels in line) and y counter (lines in frame), both zeroed at vsync=1; x zeroed at href rising.
REQ-013 Mode 0: every completed pixel SHALL be written.
REQ-014 Mode 1: pixel written only when x[0]=0 and y[0]=0; addresses contiguous (H_ACTIVE/2 per line).
REQ-015 Mode 2: dout SHALL be {8'h00, Y byte} where Y is the phase-0 byte; one write per byte pair.
REQ-016 Write latency: we, dout, addr SHALL be registered and valid exactly 1 cycle after the phase-1 byte edge; we high 1 cycle per pixel.
REQ-017 addr SHALL start at 0 each frame and increment by 1 after each write.
REQ-018 At addr = frame limit (H_ACTIVE*V_ACTIVE, or /4 in mode 1) further writes SHALL be suppressed and ovf set.
REQ-019 On href falling edge, if phase=1 (odd byte count) or x != H_ACTIVE, line_err SHALL set; partial pixel dropped.
REQ-020 frame_done SHALL pulse 1 cycle on the vsync rising edge ending an ACTIVE frame, even if errors occurred.
REQ-021 When single_shot sampled 1, after frame_done the block SHALL latch off until cap_en is sampled 0 then 1.
REQ-022 err_clr SHALL clear line_err and ovf; a set event in the same cycle SHALL win.
REQ-023 In WAIT_VS, we SHALL be 0 regardless of href.

Reset
REQ-024 On rst_n=0: FSM WAIT_VS; addr, dout, we, frame_done, line_err, ovf, counters, phase, latch-off and sampled config all 0.
REQ-025 Reset deassertion mid-frame SHALL not write until the next full vsync blanking-to-active transition.

Structure
REQ-026 Mode encoding enum and FSM state enum SHALL live in package cam_pkg.
REQ-027 One sub-module cam_sync_edge SHALL provide registered rise/fall pulses for vsync and href.

Verification
REQ-028 Mode 0, 4x2 frame, bytes 0x12,0x34,... -> 8 writes, addr 0..7, first dout 16'h1234, frame_done once.
REQ-029 Mode 1, 4x4 frame -> 4 writes, addr 0..3, pixels from x=0,2 of lines 0,2 only.
REQ-030 Mode 2, bytes 0xAB,0xCD -> dout 16'h00AB, one write.
REQ-031 Line with 7 bytes -> line_err=1, 3 writes that line, next line unaffected; err_clr -> line_err=0.
REQ-032 single_shot=1, cap_en=1, three frames -> writes only in frame 1, one frame_done pulse; vsync mid-line -> addr 0 next frame.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Purpose  : Shared types for the camera frame-capture block: capture-mode
//            encoding, frame FSM state encoding and the pixel-word packer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,   // every pixel written
    MODE_DEC2   = 2'd1,   // 2x2 decimated RGB565
    MODE_YONLY  = 2'd2,   // YUV422, luma byte only
    MODE_NONE   = 2'd3    // reserved: no writes
  } cap_mode_e;

  typedef enum logic {
    ST_WAIT_VS = 1'b0,
    ST_ACTIVE  = 1'b1
  } cap_state_e;

  // In Y-only mode the first byte of each pair is the luma sample.
  function automatic logic [15:0] pack_pixel(cap_mode_e m, logic [7:0] hi, logic [7:0] lo);
    return (m == MODE_YONLY) ? {8'h00, hi} : {hi, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : cam_frame_capture_if
// Purpose  : Groups the sensor input bus and the frame-buffer write bus.
// Ports    : vsync/href/din  - sensor timing and byte stream
//            addr/dout/we    - frame-buffer write port
//            master modport  - capture block side
//            slave modport   - sensor/memory side
// Revision : 1.0 - initial release
// ============================================================================
interface cam_frame_capture_if #(
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [7:0]        din;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       dout;
  logic              we;

  modport master (input vsync, href, din, output addr, dout, we);
  modport slave  (output vsync, href, din, input addr, dout, we);
endinterface
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : cam_sync_edge
// Purpose  : Rise/fall pulses for vsync and href, derived from a registered
//            copy of each level so the pulse lines up with the current byte.
// Ports    : clk, rst_n            - clock, async active-low reset
//            vsync, href           - sensor timing levels (pclk domain)
//            vs_rise/vs_fall       - vsync edge pulses
//            hr_rise/hr_fall       - href edge pulses
// Revision : 1.0 - initial release
// ============================================================================
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  output logic vs_rise,
  output logic vs_fall,
  output logic hr_rise,
  output logic hr_fall
);

  logic vs_q;
  logic hr_q;

  // History resets low, so a reset released mid-frame never produces a
  // spurious vsync fall: a full blanking period must be seen first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_q <= vsync;
      hr_q <= href;
    end
  end

  assign vs_rise = vsync & ~vs_q;
  assign vs_fall = ~vsync & vs_q;
  assign hr_rise = href & ~hr_q;
  assign hr_fall = ~href & hr_q;

endmodule
`default_nettype wire

// File: rtl/cam_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_frame_capture
// Purpose  : Captures a byte-serial camera stream into frame-buffer writes in
//            full RGB565, 2x2-decimated RGB565 or Y-only modes.
// Ports    : pclk, rst_n  - pixel clock, async active-low reset
//            cam          - sensor bus in, frame-buffer write bus out
//            cap_en, mode, single_shot - config, sampled during vsync blanking
//            err_clr      - clears line_err and ovf
//            frame_done   - one-cycle pulse at the end of a captured frame
//            line_err     - sticky malformed-line flag
//            ovf          - sticky address-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                pclk,
  input  logic                rst_n,
  cam_frame_capture_if.master cam,
  input  logic                cap_en,
  input  logic [1:0]          mode,
  input  logic                single_shot,
  input  logic                err_clr,
  output logic                frame_done,
  output logic                line_err,
  output logic                ovf
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] LIM_FULL = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W-1:0] LIM_DEC  = ADDR_W'((H_ACTIVE * V_ACTIVE) / 4);
  localparam logic [XW-1:0]     X_FULL   = XW'(H_ACTIVE);

  cap_state_e        state_q, state_d;
  logic              vs_rise, vs_fall, hr_rise, hr_fall;
  logic              cfg_en, cfg_ss, latched_off;
  cap_mode_e         cfg_mode;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] wr_cnt, addr_q;
  logic [15:0]       dout_q;
  logic              we_q;
  logic              in_line, byte_hi, byte_lo, keep;
  logic [ADDR_W-1:0] limit;

  cam_sync_edge u_edge (
    .clk     (pclk),
    .rst_n   (rst_n),
    .vsync   (cam.vsync),
    .href    (cam.href),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .hr_rise (hr_rise),
    .hr_fall (hr_fall)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT_VS;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_VS: if (vs_fall && cfg_en && !latched_off) state_d = ST_ACTIVE;
      ST_ACTIVE:  if (vs_rise) state_d = ST_WAIT_VS;
      default:    state_d = ST_WAIT_VS;
    endcase
  end

  // The first byte of a line is always a high/Y byte, whatever phase was left.
  always_comb begin
    in_line = (state_q == ST_ACTIVE) && !cam.vsync;
    byte_hi = in_line && cam.href && (hr_rise || !phase_q);
    byte_lo = in_line && cam.href && !hr_rise && phase_q;
    limit   = (cfg_mode == MODE_DEC2) ? LIM_DEC : LIM_FULL;
    keep    = 1'b0;
    case (cfg_mode)
      MODE_RGB565: keep = 1'b1;
      MODE_DEC2:   keep = !x_q[0] && !y_q[0];
      MODE_YONLY:  keep = 1'b1;
      default:     keep = 1'b0;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_en      <= 1'b0;
      cfg_ss      <= 1'b0;
      cfg_mode    <= MODE_RGB565;
      latched_off <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      wr_cnt      <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      we_q        <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      frame_done <= (state_q == ST_ACTIVE) && vs_rise;
      // Clears are written first so that a set later in this block wins.
      if (err_clr) begin
        line_err <= 1'b0;
        ovf      <= 1'b0;
      end
      if (cam.vsync) begin
        // Blanking: sample config, rewind counters, abort any open line.
        cfg_en   <= cap_en;
        cfg_ss   <= single_shot;
        cfg_mode <= cap_mode_e'(mode);
        phase_q  <= 1'b0;
        x_q      <= '0;
        y_q      <= '0;
        wr_cnt   <= '0;
        if (!cap_en) latched_off <= 1'b0;
        if ((state_q == ST_ACTIVE) && vs_rise && cfg_ss) latched_off <= 1'b1;
      end else if (in_line) begin
        if (byte_hi) begin
          hi_q    <= cam.din;
          phase_q <= 1'b1;
          if (hr_rise) x_q <= '0;
        end else if (byte_lo) begin
          phase_q <= 1'b0;
          x_q     <= x_q + XW'(1);
          if (keep) begin
            if (wr_cnt == limit) begin
              ovf <= 1'b1;
            end else begin
              we_q   <= 1'b1;
              addr_q <= wr_cnt;
              dout_q <= pack_pixel(cfg_mode, hi_q, cam.din);
              wr_cnt <= wr_cnt + ADDR_W'(1);
            end
          end
        end else if (hr_fall) begin
          // A dangling high byte is simply discarded with the phase reset.
          if (phase_q || (x_q != X_FULL)) line_err <= 1'b1;
          phase_q <= 1'b0;
          y_q     <= y_q + YW'(1);
        end
      end
    end
  end

  assign cam.addr = addr_q;
  assign cam.dout = dout_q;
  assign cam.we   = we_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_frame_capture
// Purpose  : Directed scoreboard bench for cam_frame_capture on a 4x4 frame.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_frame_capture;
  import cam_pkg::*;

  localparam int H  = 4;
  localparam int V  = 4;
  localparam int AW = 5;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cap_en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       single_shot = 1'b0;
  logic       err_clr = 1'b0;
  logic       frame_done, line_err, ovf;

  cam_frame_capture_if #(.ADDR_W(AW)) cam ();

  cam_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .cam         (cam),
    .cap_en      (cap_en),
    .mode        (mode),
    .single_shot (single_shot),
    .err_clr     (err_clr),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .ovf         (ovf)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int wr_seen = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] mon_exp;

  // Monitor: every write strobe pops one expected {addr,dout}.
  always @(negedge pclk) begin
    if (rst_n) begin
      if (cam.we) begin
        wr_seen++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%0d dout=%h, required no write", cam.addr, cam.dout);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({cam.addr, cam.dout} !== mon_exp) begin
            n_fail++;
            $display("FAIL write: got addr=%0d dout=%h, required addr=%0d dout=%h",
                     cam.addr, cam.dout, mon_exp[AW+15:16], mon_exp[15:0]);
          end
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(negedge pclk);
    cam.vsync = v;
    cam.href  = h;
    cam.din   = d;
  endtask

  task automatic blank(input int n);
    repeat (n) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Byte i of a line starting at s; 0x12 start gives 0x12,0x34,0x56,...
  function automatic logic [7:0] bv(input logic [7:0] s, input int i);
    return s + 8'(i * 34);
  endfunction

  function automatic logic [7:0] ls(input int l);
    return 8'h12 + 8'(l * 16);
  endfunction

  function automatic logic [15:0] px(input logic [7:0] s, input int x);
    return {bv(s, 2 * x), bv(s, 2 * x + 1)};
  endfunction

  task automatic push(input int a, input logic [15:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic line(input int nb, input logic [7:0] s);
    for (int i = 0; i < nb; i++) drive(1'b0, 1'b1, bv(s, i));
    idle(2);
  endtask

  task automatic frame(input int nl);
    blank(3);
    idle(2);
    for (int l = 0; l < nl; l++) line(2 * H, ls(l));
    blank(3);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    blank(1);
    err_clr = 1'b0;
    blank(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, f0;
    cam.vsync = 1'b0;
    cam.href  = 1'b0;
    cam.din   = 8'h00;
    repeat (3) @(negedge pclk);
    chk("rst_addr", 32'(cam.addr), 0);
    chk("rst_dout", 32'(cam.dout), 0);
    chk("rst_we", 32'(cam.we), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_line_err", 32'(line_err), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;

    // Reset released mid-frame: no writes until a blanking->active edge.
    cap_en = 1'b1;
    w0 = wr_seen;
    line(2 * H, ls(0));
    chk("post_reset_no_write", 32'(wr_seen - w0), 0);

    // Mode 0, 4x2 frame.
    mode = 2'd0; w0 = wr_seen; f0 = fd_cnt;
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < H; x++) push(l * H + x, px(ls(l), x));
    frame(2);
    chk("m0_writes", 32'(wr_seen - w0), 8);
    chk("m0_frame_done", 32'(fd_cnt - f0), 1);
    chk("m0_queue_empty", 32'(exp_q.size()), 0);
    chk("m0_line_err", 32'(line_err), 0);

    // Mode 1, 4x4 frame: x=0,2 of lines 0,2.
    mode = 2'd1; w0 = wr_seen; f0 = fd_cnt;
    push(0, px(ls(0), 0)); push(1, px(ls(0), 2));
    push(2, px(ls(2), 0)); push(3, px(ls(2), 2));
    frame(4);
    chk("m1_writes", 32'(wr_seen - w0), 4);
    chk("m1_frame_done", 32'(fd_cnt - f0), 1);
    chk("m1_ovf", 32'(ovf), 0);

    // Mode 2, bytes AB,CD: one Y write; the short line flags line_err.
    mode = 2'd2; w0 = wr_seen;
    push(0, 16'h00AB);
    blank(3); idle(2);
    line(2, 8'hAB);
    blank(3);
    chk("m2_writes", 32'(wr_seen - w0), 1);
    chk("m2_short_line_err", 32'(line_err), 1);
    clear_errs();
    chk("m2_err_clr", 32'(line_err), 0);

    // Mode 0, first line 7 bytes then a good line.
    mode = 2'd0; w0 = wr_seen;
    for (int x = 0; x < 3; x++) push(x, px(ls(0), x));
    for (int x = 0; x < H; x++) push(3 + x, px(ls(1), x));
    blank(3); idle(2);
    line(7, ls(0));
    chk("odd_line_err", 32'(line_err), 1);
    chk("odd_line_writes", 32'(wr_seen - w0), 3);
    line(2 * H, ls(1));
    blank(3);
    chk("odd_total_writes", 32'(wr_seen - w0), 7);
    chk("line_err_sticky", 32'(line_err), 1);
    clear_errs();
    chk("odd_err_clr", 32'(line_err), 0);

    // Mode 1 with 6 lines: limit of 4 reached, line 4 suppressed.
    mode = 2'd1; w0 = wr_seen;
    push(0, px(ls(0), 0)); push(1, px(ls(0), 2));
    push(2, px(ls(2), 0)); push(3, px(ls(2), 2));
    frame(6);
    chk("ovf_writes", 32'(wr_seen - w0), 4);
    chk("ovf_set", 32'(ovf), 1);
    clear_errs();
    chk("ovf_clr", 32'(ovf), 0);

    // Single shot over three frames.
    mode = 2'd0; single_shot = 1'b1; w0 = wr_seen; f0 = fd_cnt;
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < H; x++) push(l * H + x, px(ls(l), x));
    frame(2); frame(2); frame(2);
    chk("ss_writes", 32'(wr_seen - w0), 8);
    chk("ss_frame_done", 32'(fd_cnt - f0), 1);

    // Re-arm with cap_en 0 then 1; abort a line with vsync mid-line.
    cap_en = 1'b0; blank(2);
    cap_en = 1'b1; single_shot = 1'b0; w0 = wr_seen; f0 = fd_cnt;
    push(0, px(ls(0), 0)); push(1, px(ls(0), 1));
    blank(2); idle(2);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, bv(ls(0), i));
    drive(1'b1, 1'b1, 8'h00);
    blank(3);
    chk("abort_writes", 32'(wr_seen - w0), 2);
    chk("abort_frame_done", 32'(fd_cnt - f0), 1);
    chk("abort_no_line_err", 32'(line_err), 0);
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < H; x++) push(l * H + x, px(ls(l), x));
    frame(2);
    chk("rearm_writes", 32'(wr_seen - w0), 10);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
